// File: rtl/multicycle_control.sv
// Multicycle control FSM for the 32-bit custom-ISA datapath: sequences each instruction
// through fetch/decode/execute/memory/writeback, stalls on mem_ready and traps bad opcodes.
`timescale 1ns/1ps

module multicycle_control #(
    parameter int              OPW      = 6,
    parameter int              ALUW     = 5,
    parameter logic [ALUW-1:0] ALU_ADD  = ALUW'(5'b11111),
    parameter int              WAIT_MAX = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [31:0]     ins,
    input  logic            mem_ready,
    input  logic            branch_taken,
    output logic            PCWrite,
    output logic            IorD,
    output logic            IRWrite,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            MemToReg,
    output logic            RegDst,
    output logic            RegWrite,
    output logic            LinkWrite,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      PCSource,
    output logic [ALUW-1:0] ALUControl,
    output logic            illegal,
    output logic [3:0]      state_o
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADDR = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXEC_R  = 4'd6;
    localparam logic [3:0] S_EXEC_I  = 4'd7;
    localparam logic [3:0] S_ALUWB   = 4'd8;
    localparam logic [3:0] S_BRANCH  = 4'd9;
    localparam logic [3:0] S_JUMP    = 4'd10;
    localparam logic [3:0] S_TRAP    = 4'd11;

    localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_AND  = OPW'(6'b100000);
    localparam logic [OPW-1:0] OP_NOR  = OPW'(6'b100110);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(6'b010100);
    localparam logic [OPW-1:0] OP_ROLV = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_RORV = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_NORI = OPW'(6'b001110);
    localparam logic [OPW-1:0] OP_BLEU = OPW'(6'b010000);
    localparam logic [OPW-1:0] OP_JR   = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_JAL  = OPW'(6'b000011);

    // The counter only has to represent WAIT_MAX-1: the limit itself is never stored.
    localparam int             CW        = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CW-1:0]  WAIT_LAST = CW'(WAIT_MAX - 1);

    logic [3:0]      state_r;
    logic [3:0]      state_next_s;
    logic [CW-1:0]   wait_cnt_r;
    logic            illegal_r;
    logic            rdst_r;
    logic [OPW-1:0]  opcode_s;
    logic [ALUW-1:0] alu_field_s;
    logic            waiting_s;
    logic            timeout_s;
    logic            ins_unused_s;

    logic            pc_write_s;
    logic            iord_s;
    logic            ir_write_s;
    logic            mem_read_s;
    logic            mem_write_s;
    logic            mem_to_reg_s;
    logic            reg_dst_s;
    logic            reg_write_s;
    logic            link_write_s;
    logic            alu_src_a_s;
    logic [1:0]      alu_src_b_s;
    logic [1:0]      pc_source_s;
    logic [ALUW-1:0] alu_ctl_s;

    assign opcode_s     = ins[31:32-OPW];
    assign alu_field_s  = ins[31:32-ALUW];
    assign ins_unused_s = ^ins;

    assign waiting_s = (state_r == S_FETCH) || (state_r == S_MEMRD) || (state_r == S_MEMWR);
    // A completing handshake in the limit cycle takes precedence over the timeout.
    assign timeout_s = (WAIT_MAX != 0) && (wait_cnt_r == WAIT_LAST) && !mem_ready;

    // Next-state selection
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_FETCH: begin
                if (mem_ready) begin
                    state_next_s = S_DECODE;
                end else if (timeout_s) begin
                    state_next_s = S_TRAP;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode_s)
                    OP_LW, OP_SW:                                 state_next_s = S_MEMADDR;
                    OP_AND, OP_NOR, OP_NOT, OP_ROLV, OP_RORV:     state_next_s = S_EXEC_R;
                    OP_NORI:                                      state_next_s = S_EXEC_I;
                    OP_BLEU:                                      state_next_s = S_BRANCH;
                    OP_JR, OP_JAL:                                state_next_s = S_JUMP;
                    default:                                      state_next_s = S_TRAP;
                endcase
            end
            S_MEMADDR: begin
                if (opcode_s == OP_SW) begin
                    state_next_s = S_MEMWR;
                end else begin
                    state_next_s = S_MEMRD;
                end
            end
            S_MEMRD: begin
                if (mem_ready) begin
                    state_next_s = S_MEMWB;
                end else if (timeout_s) begin
                    state_next_s = S_TRAP;
                end else begin
                    state_next_s = S_MEMRD;
                end
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_next_s = S_FETCH;
                end else if (timeout_s) begin
                    state_next_s = S_TRAP;
                end else begin
                    state_next_s = S_MEMWR;
                end
            end
            S_MEMWB:  state_next_s = S_FETCH;
            S_EXEC_R: state_next_s = S_ALUWB;
            S_EXEC_I: state_next_s = S_ALUWB;
            S_ALUWB:  state_next_s = S_FETCH;
            S_BRANCH: state_next_s = S_FETCH;
            S_JUMP:   state_next_s = S_FETCH;
            S_TRAP:   state_next_s = S_TRAP;
            default:  state_next_s = S_TRAP;
        endcase
    end

    // State, wait counter, sticky trap flag and the R/I destination select
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r    <= S_FETCH;
            wait_cnt_r <= {CW{1'b0}};
            illegal_r  <= 1'b0;
            rdst_r     <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (state_next_s != state_r) begin
                wait_cnt_r <= {CW{1'b0}};
            end else if (waiting_s && !mem_ready) begin
                wait_cnt_r <= wait_cnt_r + CW'(1'b1);
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            if (state_next_s == S_TRAP) begin
                illegal_r <= 1'b1;
            end else begin
                illegal_r <= illegal_r;
            end
            if (state_r == S_EXEC_R) begin
                rdst_r <= 1'b1;
            end else if (state_r == S_EXEC_I) begin
                rdst_r <= 1'b0;
            end else begin
                rdst_r <= rdst_r;
            end
        end
    end

    // Moore output decode; only the FETCH write strobes follow mem_ready directly
    always_comb begin
        pc_write_s   = 1'b0;
        iord_s       = 1'b0;
        ir_write_s   = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        mem_to_reg_s = 1'b0;
        reg_dst_s    = 1'b0;
        reg_write_s  = 1'b0;
        link_write_s = 1'b0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = 2'b00;
        pc_source_s  = 2'b00;
        alu_ctl_s    = ALU_ADD;
        case (state_r)
            S_FETCH: begin
                mem_read_s  = 1'b1;
                alu_src_b_s = 2'b01;
                if (mem_ready) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                end else begin
                    ir_write_s = 1'b0;
                    pc_write_s = 1'b0;
                end
            end
            S_DECODE: begin
                alu_ctl_s = ALU_ADD;
            end
            S_MEMADDR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
            end
            S_MEMRD: begin
                mem_read_s = 1'b1;
                iord_s     = 1'b1;
            end
            S_MEMWB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
                reg_dst_s    = 1'b0;
            end
            S_MEMWR: begin
                mem_write_s = 1'b1;
                iord_s      = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b00;
                alu_ctl_s   = alu_field_s;
            end
            S_EXEC_I: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
                alu_ctl_s   = alu_field_s;
            end
            S_ALUWB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b0;
                reg_dst_s    = rdst_r;
            end
            S_BRANCH: begin
                pc_source_s = 2'b01;
                pc_write_s  = branch_taken;
            end
            S_JUMP: begin
                pc_write_s = 1'b1;
                if (opcode_s == OP_JAL) begin
                    pc_source_s  = 2'b11;
                    link_write_s = 1'b1;
                    reg_write_s  = 1'b1;
                end else begin
                    pc_source_s  = 2'b10;
                end
            end
            S_TRAP: begin
                alu_ctl_s = ALU_ADD;
            end
            default: begin
                alu_ctl_s = ALU_ADD;
            end
        endcase
    end

    // Enables are forced low for as long as reset is held.
    assign PCWrite    = reset_n && pc_write_s;
    assign IRWrite    = reset_n && ir_write_s;
    assign MemRead    = reset_n && mem_read_s;
    assign MemWrite   = reset_n && mem_write_s;
    assign RegWrite   = reset_n && reg_write_s;
    assign LinkWrite  = reset_n && link_write_s;
    assign IorD       = iord_s;
    assign MemToReg   = mem_to_reg_s;
    assign RegDst     = reg_dst_s;
    assign ALUSrcA    = alu_src_a_s;
    assign ALUSrcB    = alu_src_b_s;
    assign PCSource   = pc_source_s;
    assign ALUControl = alu_ctl_s;
    assign illegal    = illegal_r;
    assign state_o    = state_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: randomized instruction streams and wait
// patterns compared against an instruction-level model of the expected control sequence.
`timescale 1ns/1ps

module tb_multicycle_control;

    localparam logic [4:0] ALU_ADD   = 5'b11111;
    localparam int         WAIT_MAX  = 16;
    localparam logic [3:0] FETCH_ENC = 4'd0;

    localparam int CL_LD = 0, CL_ST = 1, CL_R = 2, CL_I = 3, CL_BR = 4,
                   CL_JR = 5, CL_JAL = 6, CL_BAD = 7;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] ins = 32'd0;
    logic        mem_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic        PCWrite, IorD, IRWrite, MemRead, MemWrite, MemToReg, RegDst;
    logic        RegWrite, LinkWrite, ALUSrcA, illegal;
    logic [1:0]  ALUSrcB, PCSource;
    logic [4:0]  ALUControl;
    logic [3:0]  state_o;

    always #5 clk = ~clk;

    multicycle_control #(.OPW(6), .ALUW(5), .ALU_ADD(ALU_ADD), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .reset_n(reset_n), .ins(ins), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .PCWrite(PCWrite), .IorD(IorD), .IRWrite(IRWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .LinkWrite(LinkWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .ALUControl(ALUControl), .illegal(illegal), .state_o(state_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected values for the current cycle; k_* marks which select fields are specified.
    logic       e_ill, e_pcw, e_iord, e_irw, e_mr, e_mw, e_m2r, e_rdst, e_rw, e_lk, e_sa;
    logic [1:0] e_sb, e_ps;
    logic [4:0] e_alu;
    logic       k_iord, k_m2r, k_rdst, k_sa, k_sb, k_ps, k_alu;
    logic [31:0] cur_ins = 32'd0;
    string      pfx = "init";

    function automatic logic rbit();
        logic [31:0] r;
        r = $urandom();
        return r[0];
    endfunction

    function automatic int op_class(input logic [5:0] op);
        case (op)
            6'b100011: return CL_LD;
            6'b101011: return CL_ST;
            6'b100000, 6'b100110, 6'b010100, 6'b000000, 6'b000010: return CL_R;
            6'b001110: return CL_I;
            6'b010000: return CL_BR;
            6'b001000: return CL_JR;
            6'b000011: return CL_JAL;
            default:   return CL_BAD;
        endcase
    endfunction

    function automatic logic [5:0] enables();
        return {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, LinkWrite};
    endfunction

    task automatic clear_exp();
        {e_ill, e_pcw, e_iord, e_irw, e_mr, e_mw, e_m2r, e_rdst, e_rw, e_lk, e_sa} = 11'd0;
        e_sb = 2'b00; e_ps = 2'b00; e_alu = 5'd0;
        {k_iord, k_m2r, k_rdst, k_sa, k_sb, k_ps, k_alu} = 7'd0;
    endtask

    // One clock cycle: drive at the falling edge, compare the settled outputs just after.
    task automatic step(input string tag, input logic rdy, input logic bt);
        logic [19:0] obs, exp, msk;
        @(negedge clk);
        reset_n = 1'b1; ins = cur_ins; mem_ready = rdy; branch_taken = bt;
        #1;
        obs = {illegal, PCWrite, IorD, IRWrite, MemRead, MemWrite, MemToReg, RegDst,
               RegWrite, LinkWrite, ALUSrcA, ALUSrcB, PCSource, ALUControl};
        exp = {e_ill, e_pcw, e_iord, e_irw, e_mr, e_mw, e_m2r, e_rdst,
               e_rw, e_lk, e_sa, e_sb, e_ps, e_alu};
        msk = {1'b1, 1'b1, k_iord, 1'b1, 1'b1, 1'b1, k_m2r, k_rdst, 1'b1, 1'b1, k_sa,
               {2{k_sb}}, {2{k_ps}}, {5{k_alu}}};
        chk({pfx, ":", tag}, 32'(obs & msk), 32'(exp & msk));
    endtask

    task automatic exp_fetch();
        clear_exp();
        e_mr = 1'b1; k_iord = 1'b1; k_sa = 1'b1; k_sb = 1'b1; e_sb = 2'b01;
        k_alu = 1'b1; e_alu = ALU_ADD;
    endtask

    task automatic ph_fetch_wait(input int nw);
        for (int i = 0; i < nw; i++) begin
            exp_fetch();
            step("fetch_wait", 1'b0, rbit());
        end
    endtask

    task automatic ph_fetch(input int nw);
        ph_fetch_wait(nw);
        exp_fetch();
        e_irw = 1'b1; e_pcw = 1'b1; k_ps = 1'b1; e_ps = 2'b00;
        step("fetch", 1'b1, rbit());
    endtask

    task automatic ph_decode();
        clear_exp();
        step("decode", rbit(), rbit());
    endtask

    task automatic ph_memaddr();
        clear_exp();
        k_sa = 1'b1; e_sa = 1'b1; k_sb = 1'b1; e_sb = 2'b10; k_alu = 1'b1; e_alu = ALU_ADD;
        step("memaddr", rbit(), rbit());
    endtask

    task automatic ph_mem(input logic wr, input int nw, input logic finish);
        for (int i = 0; i < nw; i++) begin
            clear_exp(); e_mr = !wr; e_mw = wr; k_iord = 1'b1; e_iord = 1'b1;
            step(wr ? "memwr_wait" : "memrd_wait", 1'b0, rbit());
        end
        if (finish) begin
            clear_exp(); e_mr = !wr; e_mw = wr; k_iord = 1'b1; e_iord = 1'b1;
            step(wr ? "memwr" : "memrd", 1'b1, rbit());
        end
    endtask

    task automatic ph_writeback(input logic from_mem, input logic rd);
        clear_exp();
        e_rw = 1'b1; k_m2r = 1'b1; e_m2r = from_mem; k_rdst = 1'b1; e_rdst = rd;
        step(from_mem ? "memwb" : "aluwb", rbit(), rbit());
    endtask

    task automatic ph_exec(input logic imm);
        logic [31:0] iv;
        iv = cur_ins;
        clear_exp();
        k_sa = 1'b1; e_sa = 1'b1; k_sb = 1'b1; e_sb = imm ? 2'b10 : 2'b00;
        k_alu = 1'b1; e_alu = iv[31:27];
        step(imm ? "exec_i" : "exec_r", rbit(), rbit());
    endtask

    task automatic ph_trap(input int n);
        for (int i = 0; i < n; i++) begin
            clear_exp(); e_ill = 1'b1;
            step("trap", rbit(), rbit());
        end
    endtask

    // Holds reset over two rising edges; the next step() releases it.
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; mem_ready = 1'b1; branch_taken = rbit();
        #1;
        chk({pfx, ":rst_en_now"}, 32'(enables()), 32'd0);
        @(negedge clk);
        #1;
        chk({pfx, ":rst_state"}, 32'(state_o), 32'(FETCH_ENC));
        chk({pfx, ":rst_illegal"}, 32'(illegal), 32'd0);
        chk({pfx, ":rst_en"}, 32'(enables()), 32'd0);
    endtask

    task automatic run_instr(input string name, input logic [31:0] iv, input int wf,
                             input int wm, input logic bt);
        logic [31:0] r;
        pfx = name;
        cur_ins = iv;
        r = iv;
        ph_fetch(wf);
        ph_decode();
        case (op_class(r[31:26]))
            CL_LD: begin ph_memaddr(); ph_mem(1'b0, wm, 1'b1); ph_writeback(1'b1, 1'b0); end
            CL_ST: begin ph_memaddr(); ph_mem(1'b1, wm, 1'b1); end
            CL_R:  begin ph_exec(1'b0); ph_writeback(1'b0, 1'b1); end
            CL_I:  begin ph_exec(1'b1); ph_writeback(1'b0, 1'b0); end
            CL_BR: begin
                clear_exp(); e_pcw = bt; k_ps = 1'b1; e_ps = 2'b01;
                step("branch", rbit(), bt);
            end
            CL_JR, CL_JAL: begin
                clear_exp(); e_pcw = 1'b1; k_ps = 1'b1;
                e_ps = (op_class(r[31:26]) == CL_JAL) ? 2'b11 : 2'b10;
                e_lk = (op_class(r[31:26]) == CL_JAL);
                e_rw = e_lk;
                step("jump", rbit(), rbit());
            end
            default: begin ph_trap(12); do_reset(); end
        endcase
    endtask

    logic [5:0] ops [10] = '{6'b100011, 6'b101011, 6'b100000, 6'b100110, 6'b010100,
                             6'b000000, 6'b000010, 6'b001110, 6'b010000, 6'b001000};

    initial begin
        pfx = "init";
        do_reset();

        run_instr("lw",       32'h8C220004, 0, 0, 1'b0);
        run_instr("sw_stall", 32'hAC220008, 0, 3, 1'b0);
        run_instr("bleu_nt",  32'h40221000, 0, 0, 1'b0);
        run_instr("bleu_t",   32'h40221000, 0, 0, 1'b1);
        run_instr("jr",       32'h20200000, 0, 0, 1'b0);
        run_instr("jal",      32'h0C000040, 0, 0, 1'b0);
        run_instr("and",      32'h80221800, 1, 0, 1'b0);
        run_instr("nori",     32'h3822FFFF, 2, 0, 1'b1);
        run_instr("bad_op",   32'hFC000000, 0, 0, 1'b0);

        // Fetch timeout: WAIT_MAX idle cycles lead to TRAP.
        pfx = "to_fetch"; cur_ins = 32'h8C220004;
        ph_fetch_wait(WAIT_MAX);
        ph_trap(3);
        do_reset();
        // Ready in the limit cycle wins.
        run_instr("to_edge",  32'h98221800, WAIT_MAX - 1, 0, 1'b0);
        // The counter restarts on each state change.
        run_instr("to_split", 32'h8C220004, WAIT_MAX - 1, WAIT_MAX - 1, 1'b0);
        // Store stalled past the limit.
        pfx = "to_memwr"; cur_ins = 32'hAC220008;
        ph_fetch(2); ph_decode(); ph_memaddr();
        ph_mem(1'b1, WAIT_MAX, 1'b0);
        ph_trap(2);
        do_reset();
        // Reset in the middle of a load, then a clean restart.
        pfx = "midrst"; cur_ins = 32'h8C220004;
        ph_fetch(1); ph_decode(); ph_memaddr();
        do_reset();
        run_instr("after_rst", 32'h8C220004, 0, 0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            logic [31:0] r;
            logic [5:0]  op;
            int          sel;
            r = $urandom();
            sel = $urandom_range(0, 10);
            if (sel == 10) begin
                op = r[31:26];
            end else begin
                op = ops[sel];
            end
            run_instr($sformatf("rnd%0d", n), {op, r[25:0]}, $urandom_range(0, 3),
                      $urandom_range(0, 3), rbit());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed no end, expected end");
        $fatal(1);
    end

endmodule
